fb_region_sweep: RTL

//  Parametrised framebuffer sweeper: walks a rectangular pixel region and issues one

---
 rtl/fb_region_sweep.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fb_region_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : fb_region_sweep
//  Description : Framebuffer region sweeper. Walks a clipped rectangular pixel
//                region in raster or column-major order and issues one
//                datapath instruction per pixel over the start_dp/finished_dp
//                handshake. Opcode, origin, size and scan order are latched
//                at the start of each run.
//  Ports       : clock_i/reset_i      clock, synchronous active-high reset
//                start_i/abort_i      run control (start in IDLE, sticky abort)
//                opcode_i,x0_i,y0_i,
//                w_i,h_i,col_major_i  run configuration, latched on start
//                finished_o/done_o    idle level / end-of-run pulse
//                aborted_o            last run ended by abort
//                pixel_count_o        pixels completed (saturating)
//                start_dp_o,
//                instruction_dp_o     instruction request to datapath
//                finished_dp_i,
//                result_dp_i          datapath completion and result
//                checksum_o           sum of results (FB_SWEEP_CHECKSUM_EN only)
//  Config      : define FB_SWEEP_CHECKSUM_EN to add the result checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_region_sweep #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int OPCODE_W = 4,
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [X_W-1:0]      x0_i,
    input  logic [Y_W-1:0]      y0_i,
    input  logic [X_W-1:0]      w_i,
    input  logic [Y_W-1:0]      h_i,
    input  logic                col_major_i,
    output logic                finished_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic [15:0]         pixel_count_o,
    output logic                start_dp_o,
    output logic [INSTR_W-1:0]  instruction_dp_o,
    input  logic                finished_dp_i,
`ifdef FB_SWEEP_CHECKSUM_EN
    output logic [RESULT_W-1:0] checksum_o,
`endif
    input  logic [RESULT_W-1:0] result_dp_i
);

    localparam int           PAD_W   = INSTR_W - OPCODE_W - Y_W - X_W;
    localparam logic [X_W:0] C_X_MAX = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] C_Y_MAX = (Y_W+1)'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                state_q;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [X_W-1:0]        x0_q, x_q, x_end_q;
    logic [Y_W-1:0]        y0_q, y_q, y_end_q;
    logic                  col_major_q;
    logic                  abort_q;
    logic                  empty_q;   // empty run pending its done pulse

    // Inclusive region end, one bit wider so x0+w-1 cannot wrap before clipping.
    logic [X_W:0]   x_last_d;
    logic [Y_W:0]   y_last_d;
    logic [X_W-1:0] x_end_d;
    logic [Y_W-1:0] y_end_d;
    logic           empty_d;
    logic           last_pixel;

    assign x_last_d = {1'b0, x0_i} + {1'b0, w_i} - (X_W+1)'(1);
    assign y_last_d = {1'b0, y0_i} + {1'b0, h_i} - (Y_W+1)'(1);
    assign x_end_d  = (x_last_d > C_X_MAX) ? C_X_MAX[X_W-1:0] : x_last_d[X_W-1:0];
    assign y_end_d  = (y_last_d > C_Y_MAX) ? C_Y_MAX[Y_W-1:0] : y_last_d[Y_W-1:0];
    assign empty_d  = (w_i == '0) || (h_i == '0) ||
                      ({1'b0, x0_i} > C_X_MAX) || ({1'b0, y0_i} > C_Y_MAX);

    assign last_pixel = (x_q == x_end_q) && (y_q == y_end_q);

`ifndef FB_SWEEP_CHECKSUM_EN
    logic unused_result;
    assign unused_result = ^result_dp_i;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q          <= S_IDLE;
            opcode_q         <= '0;
            x0_q             <= '0;
            y0_q             <= '0;
            x_q              <= '0;
            y_q              <= '0;
            x_end_q          <= '0;
            y_end_q          <= '0;
            col_major_q      <= 1'b0;
            abort_q          <= 1'b0;
            empty_q          <= 1'b0;
            finished_o       <= 1'b1;
            done_o           <= 1'b0;
            aborted_o        <= 1'b0;
            pixel_count_o    <= '0;
            start_dp_o       <= 1'b0;
            instruction_dp_o <= '0;
`ifdef FB_SWEEP_CHECKSUM_EN
            checksum_o       <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (empty_q) begin
                        // Empty run: finish one cycle after start, no dp traffic.
                        empty_q    <= 1'b0;
                        done_o     <= 1'b1;
                        finished_o <= 1'b1;
                    end else if (start_i) begin
                        opcode_q      <= opcode_i;
                        x0_q          <= x0_i;
                        y0_q          <= y0_i;
                        x_q           <= x0_i;
                        y_q           <= y0_i;
                        x_end_q       <= x_end_d;
                        y_end_q       <= y_end_d;
                        col_major_q   <= col_major_i;
                        abort_q       <= 1'b0;
                        aborted_o     <= 1'b0;
                        pixel_count_o <= '0;
                        finished_o    <= 1'b0;
`ifdef FB_SWEEP_CHECKSUM_EN
                        checksum_o    <= '0;
`endif
                        if (empty_d) begin
                            empty_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    start_dp_o       <= 1'b1;
                    instruction_dp_o <= {opcode_q, {PAD_W{1'b0}}, y_q, x_q};
                    state_q          <= S_HOLD;
                    if (abort_i) abort_q <= 1'b1;
                end
                S_HOLD: begin
                    state_q <= S_WAIT;
                    if (abort_i) abort_q <= 1'b1;
                end
                S_WAIT: begin
                    start_dp_o <= 1'b0;
                    if (finished_dp_i) begin
                        if (pixel_count_o != 16'hFFFF) begin
                            pixel_count_o <= pixel_count_o + 16'd1;
                        end
`ifdef FB_SWEEP_CHECKSUM_EN
                        checksum_o <= checksum_o + result_dp_i;
`endif
                        if (last_pixel) begin
                            // A natural end takes precedence over a coincident abort.
                            state_q    <= S_IDLE;
                            done_o     <= 1'b1;
                            finished_o <= 1'b1;
                        end else if (abort_q || abort_i) begin
                            state_q    <= S_IDLE;
                            done_o     <= 1'b1;
                            finished_o <= 1'b1;
                            aborted_o  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            if (col_major_q) begin
                                if (y_q == y_end_q) begin
                                    y_q <= y0_q;
                                    x_q <= x_q + X_W'(1);
                                end else begin
                                    y_q <= y_q + Y_W'(1);
                                end
                            end else begin
                                if (x_q == x_end_q) begin
                                    x_q <= x0_q;
                                    y_q <= y_q + Y_W'(1);
                                end else begin
                                    x_q <= x_q + X_W'(1);
                                end
                            end
                        end
                    end else if (abort_i) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
